cache_dati_fisica: RTL

//  Direct-mapped, write-through, no-write-allocate data cache on the physical side of the MMU.

---
 rtl/cache_dati_fisica_pkg.sv | 52 +++++
 rtl/cache_dati_fisica_if.sv | 35 +++
 rtl/cache_dati_fisica_linee.sv | 52 +++++
 rtl/cache_dati_fisica.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/cache_dati_fisica_pkg.sv
// Shared types and constants for the physical-side data cache.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cache_dati_fisica_pkg;

    localparam int N     = 32;           // address/data width, addresses are word addresses
    localparam int IDX   = 4;            // index bits
    localparam int LINES = 1 << IDX;     // one-word lines
    localparam int TAGW  = N - IDX;

    localparam logic [1:0] OP_READ   = 2'b11;
    localparam logic [1:0] OP_WRITE  = 2'b10;
    localparam logic       ESITO_OK  = 1'b0;
    localparam logic       ESITO_ERR = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        WAITM  = 2'd2
    } state_t;

    // Request captured from the MMU when its toggle is consumed.
    typedef struct packed {
        logic [1:0]   op;
        logic [N-1:0] ind;
        logic [N-1:0] dat;
    } req_t;

    // Reply toward the MMU.
    typedef struct packed {
        logic [N-1:0] dataout;
        logic         esito;
        logic         ackout;
    } rsp_t;

    // Request toward main memory.
    typedef struct packed {
        logic         rdy;
        logic [1:0]   op;
        logic [N-1:0] ind;
        logic [N-1:0] dat;
    } mreq_t;

    function automatic logic [IDX-1:0] ind_idx(input logic [N-1:0] ind);
        return ind[IDX-1:0];
    endfunction

    function automatic logic [TAGW-1:0] ind_tag(input logic [N-1:0] ind);
        return ind[N-1:IDX];
    endfunction

endpackage

// File: rtl/cache_dati_fisica_if.sv
// Toggle-handshake buses around the cache: MMU side and main-memory side.
// Latency: n/a (wires only).
// Backpressure: none; one outstanding request per bus, signalled by level toggles.
//   mmu: rdyin/op/ind/datain/flush from the MMU, dataout/esito/ackout back to it.
//   mem: rdyoutm/opoutm/indoutm/dataoutm to memory, datainm/esitom/ackinm back.
interface cache_dati_fisica_mmu_if;
    import cache_dati_fisica_pkg::*;

    logic         rdyin;
    logic [1:0]   op;
    logic [N-1:0] ind;
    logic [N-1:0] datain;
    logic         flush;
    logic [N-1:0] dataout;
    logic         esito;
    logic         ackout;

    modport master (output rdyin, op, ind, datain, flush, input dataout, esito, ackout);
    modport slave  (input rdyin, op, ind, datain, flush, output dataout, esito, ackout);
endinterface

interface cache_dati_fisica_mem_if;
    import cache_dati_fisica_pkg::*;

    logic         rdyoutm;
    logic [1:0]   opoutm;
    logic [N-1:0] indoutm;
    logic [N-1:0] dataoutm;
    logic [N-1:0] datainm;
    logic         esitom;
    logic         ackinm;

    modport master (output rdyoutm, opoutm, indoutm, dataoutm, input datainm, esitom, ackinm);
    modport slave  (input rdyoutm, opoutm, indoutm, dataoutm, output datainm, esitom, ackinm);
endinterface

// File: rtl/cache_dati_fisica_linee.sv
// Line store: LINES x {valid, tag, data}, combinational read, one synchronous write port.
// Latency: read same cycle; writes and clear-all visible after the next clock edge.
// Backpressure: none; clear_all wins over a write to the valid bit in the same cycle.
//   rd_idx -> rd_valid/rd_tag/rd_data; wr_idx with per-field enables; clear_all drops every valid.
module cache_dati_fisica_linee
    import cache_dati_fisica_pkg::*;
(
    input  logic            clock,
    input  logic            reset_n,
    input  logic [IDX-1:0]  rd_idx,
    output logic            rd_valid,
    output logic [TAGW-1:0] rd_tag,
    output logic [N-1:0]    rd_data,
    input  logic [IDX-1:0]  wr_idx,
    input  logic            wr_valid_en,
    input  logic            wr_valid,
    input  logic            wr_tag_en,
    input  logic [TAGW-1:0] wr_tag,
    input  logic            wr_data_en,
    input  logic [N-1:0]    wr_data,
    input  logic            clear_all
);

    logic [LINES-1:0] valid_q;
    logic [TAGW-1:0]  tag_q  [LINES];
    logic [N-1:0]     data_q [LINES];

    // Only valid bits need reset; tag/data are meaningless while invalid.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
        end else if (clear_all) begin
            valid_q <= '0;
        end else if (wr_valid_en) begin
            valid_q[wr_idx] <= wr_valid;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_tag_en) begin
            tag_q[wr_idx] <= wr_tag;
        end
        if (wr_data_en) begin
            data_q[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/cache_dati_fisica.sv
// Direct-mapped, write-through, no-write-allocate data cache behind the MMU.
// Latency: hit/invalid-op reply 2 edges after the request toggle is sampled; miss/write
//   issue to memory at edge 2, reply 1 edge after the memory toggle is sampled.
// Backpressure: single outstanding request; new toggles are only examined in IDLE.
//   Ports: clock, reset_n (async active-low), mmu (slave side), mem (master side).
module cache_dati_fisica
    import cache_dati_fisica_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset_n,
    cache_dati_fisica_mmu_if.slave mmu,
    cache_dati_fisica_mem_if.master mem
);

    state_t state_q, state_d;
    logic   rdy_seen_q, rdy_seen_d;
    logic   ackm_seen_q, ackm_seen_d;
    logic   flush_pend_q, flush_pend_d;
    req_t   req_q, req_d;

    // FSM-side reply/memory registers, then a second stage driving the ports.
    // The extra stage keeps every interface output on a flop of its own and
    // sets the reply timing: decision at edge N, visible on the port after edge N+1.
    rsp_t   rsp_q, rsp_d, rsp_o;
    mreq_t  mreq_q, mreq_d, mreq_o;

    logic            rd_valid;
    logic [TAGW-1:0] rd_tag;
    logic [N-1:0]    rd_data;
    logic            hit;
    logic            clear_all;
    logic            wr_valid_en, wr_valid, wr_tag_en, wr_data_en;
    logic [N-1:0]    wr_data;

    cache_dati_fisica_linee u_linee (
        .clock       (clock),
        .reset_n     (reset_n),
        .rd_idx      (ind_idx(req_q.ind)),
        .rd_valid    (rd_valid),
        .rd_tag      (rd_tag),
        .rd_data     (rd_data),
        .wr_idx      (ind_idx(req_q.ind)),
        .wr_valid_en (wr_valid_en),
        .wr_valid    (wr_valid),
        .wr_tag_en   (wr_tag_en),
        .wr_tag      (ind_tag(req_q.ind)),
        .wr_data_en  (wr_data_en),
        .wr_data     (wr_data),
        .clear_all   (clear_all)
    );

    assign hit = rd_valid && (rd_tag == ind_tag(req_q.ind));

    always_comb begin
        state_d      = state_q;
        rdy_seen_d   = rdy_seen_q;
        ackm_seen_d  = ackm_seen_q;
        req_d        = req_q;
        rsp_d        = rsp_q;
        mreq_d       = mreq_q;
        // A flush seen while busy is remembered until the next IDLE cycle.
        flush_pend_d = flush_pend_q | mmu.flush;
        clear_all    = 1'b0;
        wr_valid_en  = 1'b0;
        wr_valid     = 1'b0;
        wr_tag_en    = 1'b0;
        wr_data_en   = 1'b0;
        wr_data      = req_q.dat;

        case (state_q)
            IDLE: begin
                // Clearing here lands on the same edge as a request latch, so
                // LOOKUP on the next cycle already sees the flushed array.
                clear_all    = flush_pend_q | mmu.flush;
                flush_pend_d = 1'b0;
                if (mmu.rdyin != rdy_seen_q) begin
                    rdy_seen_d = mmu.rdyin;
                    req_d.op   = mmu.op;
                    req_d.ind  = mmu.ind;
                    req_d.dat  = mmu.datain;
                    state_d    = LOOKUP;
                end
            end

            LOOKUP: begin
                if (req_q.op == OP_READ) begin
                    if (hit) begin
                        rsp_d.dataout = rd_data;
                        rsp_d.esito   = ESITO_OK;
                        rsp_d.ackout  = ~rsp_q.ackout;
                        state_d       = IDLE;
                    end else begin
                        mreq_d.rdy = ~mreq_q.rdy;
                        mreq_d.op  = OP_READ;
                        mreq_d.ind = req_q.ind;
                        state_d    = WAITM;
                    end
                end else if (req_q.op == OP_WRITE) begin
                    // Write-through without allocate: refresh data only if resident.
                    wr_data_en = hit;
                    mreq_d.rdy = ~mreq_q.rdy;
                    mreq_d.op  = OP_WRITE;
                    mreq_d.ind = req_q.ind;
                    mreq_d.dat = req_q.dat;
                    state_d    = WAITM;
                end else begin
                    rsp_d.esito  = ESITO_ERR;
                    rsp_d.ackout = ~rsp_q.ackout;
                    state_d      = IDLE;
                end
            end

            WAITM: begin
                if (mem.ackinm != ackm_seen_q) begin
                    ackm_seen_d = mem.ackinm;
                    if (mem.esitom == ESITO_OK) begin
                        rsp_d.esito = ESITO_OK;
                        if (req_q.op == OP_READ) begin
                            wr_valid_en   = 1'b1;
                            wr_valid      = 1'b1;
                            wr_tag_en     = 1'b1;
                            wr_data_en    = 1'b1;
                            wr_data       = mem.datainm;
                            rsp_d.dataout = mem.datainm;
                        end
                    end else begin
                        rsp_d.esito = ESITO_ERR;
                        // A failed write may have left the line newer than memory.
                        if (req_q.op == OP_WRITE) begin
                            wr_valid_en = 1'b1;
                            wr_valid    = 1'b0;
                        end
                    end
                    rsp_d.ackout = ~rsp_q.ackout;
                    state_d      = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            rdy_seen_q   <= 1'b0;
            ackm_seen_q  <= 1'b0;
            flush_pend_q <= 1'b0;
            req_q        <= '0;
            rsp_q        <= '0;
            mreq_q       <= '0;
            rsp_o        <= '0;
            mreq_o       <= '0;
        end else begin
            state_q      <= state_d;
            rdy_seen_q   <= rdy_seen_d;
            ackm_seen_q  <= ackm_seen_d;
            flush_pend_q <= flush_pend_d;
            req_q        <= req_d;
            rsp_q        <= rsp_d;
            mreq_q       <= mreq_d;
            rsp_o        <= rsp_q;
            mreq_o       <= mreq_q;
        end
    end

    assign mmu.dataout  = rsp_o.dataout;
    assign mmu.esito    = rsp_o.esito;
    assign mmu.ackout   = rsp_o.ackout;
    assign mem.rdyoutm  = mreq_o.rdy;
    assign mem.opoutm   = mreq_o.op;
    assign mem.indoutm  = mreq_o.ind;
    assign mem.dataoutm = mreq_o.dat;

endmodule
